citadel_sentinel_seq: RTL

//  Second-generation Sentinel Lock. Unlocks only after the full KEY_LEN-word key sequence is

---
 rtl/citadel_sentinel_seq.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/citadel_sentinel_seq.sv
// Sentinel Lock: strobed multi-word key entry with fail counting, timed lockout and hold auto-relock.
// Define CITADEL_TAMPER_EN to enable the tamper latch (BRICK state, cleared only by rst_n).
module citadel_sentinel_seq #(
  parameter int                         KEY_W       = 8,
  parameter int                         KEY_LEN     = 4,
  parameter logic [KEY_W*KEY_LEN-1:0]   KEY_SEQ     = 32'hB65AC319,
  parameter int                         MAX_FAIL    = 3,
  parameter int                         LOCKOUT_CYC = 1024,
  parameter int                         ENTRY_TO    = 256,
  parameter int                         HOLD_CYC    = 4096,
  parameter int                         TAMPER_W    = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [KEY_W-1:0]              key_in,
  input  logic                          key_valid,
  input  logic                          relock,
  input  logic [TAMPER_W-1:0]           tamper_in,
  output logic [7:0]                    seg_out,
  output logic [7:0]                    status_out,
  output logic [2:0]                    state_o,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int IDX_W   = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam int TMR_MX0 = (LOCKOUT_CYC > ENTRY_TO) ? LOCKOUT_CYC : ENTRY_TO;
  localparam int TMR_MAX = (HOLD_CYC > TMR_MX0) ? HOLD_CYC : TMR_MX0;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [FAIL_W-1:0] FAIL_MAX   = FAIL_W'(MAX_FAIL);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(KEY_LEN - 1);
  localparam logic [TMR_W-1:0]  ENTRY_LAST = TMR_W'(ENTRY_TO - 1);
  localparam logic [TMR_W-1:0]  LOCK_LAST  = TMR_W'(LOCKOUT_CYC - 1);
  localparam logic [TMR_W-1:0]  HOLD_LAST  = TMR_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  typedef enum logic [2:0] {
    LOCKED   = 3'd0,
    ENTRY    = 3'd1,
    UNLOCKED = 3'd2,
    LOCKOUT  = 3'd3,
    BRICK    = 3'd4
  } state_t;

  state_t              state, st_nx;
  logic [IDX_W-1:0]    idx, idx_nx, word_idx;
  logic                err, err_nx, seq_err, seq_last;
  logic [FAIL_W-1:0]   fail_nx;
  logic [TMR_W-1:0]    tmr, tmr_nx;
  logic                tamper_hit;

  function automatic logic [KEY_W-1:0] key_word(input logic [IDX_W-1:0] i);
    return KEY_SEQ[(KEY_LEN - 1 - int'(i)) * KEY_W +: KEY_W];
  endfunction

  function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v);
    return (v == FAIL_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] seg_of(input state_t s, input logic en);
    logic [7:0] seg;
    seg = 8'hC7;
    if (s == BRICK)         seg = 8'h00;
    else if (!en)           seg = 8'hFF;
    else if (s == UNLOCKED) seg = 8'hC1;
    else if (s == LOCKOUT)  seg = 8'hBF;
    return seg;
  endfunction

`ifdef CITADEL_TAMPER_EN
  logic                armed;
  logic [TAMPER_W-1:0] snap;

  // Snapshot follows tamper_in every cycle; any change from the previous cycle trips the latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      snap  <= '0;
    end else begin
      armed <= 1'b1;
      snap  <= tamper_in;
    end
  end

  assign tamper_hit = armed && (tamper_in != snap);
`else
  logic unused_tamper;
  assign unused_tamper = ^tamper_in;
  assign tamper_hit    = 1'b0;
`endif

  // LOCKED compares against word 0, so KEY_LEN=1 completes without visiting ENTRY.
  assign word_idx = (state == ENTRY) ? idx : '0;
  assign seq_err  = ((state == ENTRY) && err) || (key_in != key_word(word_idx));
  assign seq_last = (word_idx == IDX_LAST);

  always_comb begin
    st_nx   = state;
    idx_nx  = idx;
    err_nx  = err;
    fail_nx = fail_cnt;
    tmr_nx  = tmr;
    if (tamper_hit) begin
      st_nx  = BRICK;
      idx_nx = '0;
      err_nx = 1'b0;
      tmr_nx = '0;
    end else if (ena) begin
      unique case (state)
        LOCKED, ENTRY: begin
          if (key_valid) begin
            tmr_nx = '0;
            if (seq_last) begin
              idx_nx = '0;
              err_nx = 1'b0;
              if (!seq_err) begin
                st_nx   = UNLOCKED;
                fail_nx = '0;
              end else begin
                fail_nx = sat_inc(fail_cnt);
                st_nx   = (sat_inc(fail_cnt) == FAIL_MAX) ? LOCKOUT : LOCKED;
              end
            end else begin
              st_nx  = ENTRY;
              idx_nx = word_idx + 1'b1;
              err_nx = seq_err;
            end
          end else if (state == ENTRY) begin
            if (tmr == ENTRY_LAST) begin
              st_nx  = LOCKED;
              idx_nx = '0;
              err_nx = 1'b0;
              tmr_nx = '0;
            end else begin
              tmr_nx = tmr + 1'b1;
            end
          end
        end
        UNLOCKED: begin
          if (relock || ((HOLD_CYC > 0) && (tmr == HOLD_LAST))) begin
            st_nx  = LOCKED;
            tmr_nx = '0;
          end else if (HOLD_CYC > 0) begin
            tmr_nx = tmr + 1'b1;
          end
        end
        LOCKOUT: begin
          if (tmr == LOCK_LAST) begin
            st_nx   = LOCKED;
            fail_nx = '0;
            tmr_nx  = '0;
          end else begin
            tmr_nx = tmr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with state_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOCKED;
      idx        <= '0;
      err        <= 1'b0;
      fail_cnt   <= '0;
      tmr        <= '0;
      seg_out    <= 8'hC7;
      status_out <= 8'h00;
    end else begin
      state      <= st_nx;
      idx        <= idx_nx;
      err        <= err_nx;
      fail_cnt   <= fail_nx;
      tmr        <= tmr_nx;
      seg_out    <= seg_of(st_nx, ena);
      status_out <= (ena && (st_nx == UNLOCKED)) ? 8'hFF : 8'h00;
    end
  end

  assign state_o = state;

endmodule
